fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO.
- On a start command it pops exactly len_i words from the FIFO read port and presents them on a valid/ready output stream.
- A 3-entry elastic buffer absorbs the FIFO's 1-cycle read latency, so throughput is one word per cycle under no back-pressure.
- Sits between a FIFO and any downstream consumer, such as a packetiser or DMA write path.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- LEN_WIDTH, 8, width of burst length and counters; max burst is 2^LEN_WIDTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  burst request; sampled only in IDLE.
- len_i  in  LEN_WIDTH  burst length in words; latched when start_i is accepted.
- busy_o  out  1  high while in READ.
- done_o  out  1  single-cycle pulse when the burst completes.
- rd_count_o  out  LEN_WIDTH  words delivered on the stream in the current or last burst.
- rden_o  out  1  FIFO read enable.
- rdata_i  in  DATA_WIDTH  FIFO read data; valid the cycle after the edge that sampled rden_o=1.
- empty_i  in  1  FIFO empty flag.
- m_valid_o  out  1  stream valid.
- m_data_o  out  DATA_WIDTH  stream data.
- m_ready_i  in  1  stream ready.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all counters, occupancy and inflight cleared.
  - Outputs after the edge: busy_o=0, done_o=0, rd_count_o=0, rden_o=0, m_valid_o=0, m_data_o=0.
  - Buffer contents and any in-flight FIFO word are discarded; reset has priority over every other event.
- FSM states:
  - IDLE: start_i=1 latches len, clears issued/delivered counters. Next state is READ if len!=0, else DONE.
  - READ: issue reads and deliver words. Go to DONE on the edge where delivered+handshake reaches len.
  - DONE: done_o=1 for exactly this one cycle, then IDLE. start_i is ignored in DONE and READ.
- rden_o (combinational from registered state and empty_i):
  - rden_o = (state==READ) & !empty_i & (issued<len) & (occ+inflight<3).
  - No combinational path from m_ready_i to rden_o.
  - rden_o is never asserted while empty_i=1.
- Read tracking:
  - inflight is a 1-bit register equal to rden_o of the previous cycle.
  - When inflight=1, rdata_i is written into the buffer tail at the next edge.
  - issued increments on every edge where rden_o=1.
- Buffer and stream:
  - 3-entry circular buffer with head/tail pointers mod 3; occ ranges 0..3.
  - occ+inflight never exceeds 3, so the buffer never overflows.
  - m_valid_o = (occ!=0); m_data_o = head entry.
  - A handshake is m_valid_o & m_ready_i: head advances, delivered and rd_count_o increment.
  - A simultaneous capture and pop leaves occ unchanged.
  - While m_valid_o=1 and m_ready_i=0, m_data_o holds stable and order is preserved.
- Latency and throughput:
  - Edge E0 samples start_i; rden_o is high in the cycle after E0; the first m_valid_o appears after E2 (2 cycles).
  - With m_ready_i=1 and the FIFO non-empty, one word per cycle is delivered.
- FIFO empty mid-burst: remain in READ with rden_o=0 until empty_i=0; there is no timeout.
- rd_count_o is cleared at start and holds its final value in IDLE until the next start.

Test Plan:
1. Reset: assert rst for 2 edges mid-stream -> after the first edge all outputs are 0, state IDLE, rden_o=0 even with empty_i=0.
2. Full-rate burst: FIFO preloaded with 0..7, len_i=8, m_ready_i=1 ->
   - rden_o high for exactly 8 consecutive cycles starting 1 cycle after the start edge.
   - m_data_o = 0,1,...,7 on consecutive cycles, first valid 2 cycles after start.
   - done_o pulses once after the last handshake; rd_count_o=8; busy_o=0 afterwards.
3. Back-pressure: preload 0..7, len_i=8, m_ready_i toggling 1,0,1,0 ->
   - all 8 words delivered in order with none lost or duplicated.
   - m_data_o stable during stall cycles; occ+inflight never exceeds 3; rden_o=8 total.
4. Underflow stall: FIFO holds 3 words (0xA0..0xA2), len_i=5 ->
   - 3 words delivered, then busy_o=1 and rden_o=0 while empty.
   - write 0xA3, 0xA4 -> both delivered, done_o pulses, rd_count_o=5.
5. Zero length: start_i with len_i=0 -> done_o=1 on the cycle after the start edge, rden_o never asserted, rd_count_o=0.
6. Start ignored and reset mid-burst:
   - start_i pulses during READ -> no effect on len or counters.
   - rst at word 4 of 8 -> next cycle m_valid_o=0, rden_o=0, rd_count_o=0, and no stale word appears afterwards.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from a synchronous FIFO
// and replays it on a valid/ready stream through a 3-entry buffer.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  rd_count_o,
    output logic                  rden_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  empty_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  delivered_q;
    logic                  inflight_q;
    logic [1:0]            head_q;
    logic [1:0]            tail_q;
    logic [1:0]            occ_q;
    logic [DATA_WIDTH-1:0] mem_q [3];

    logic start_ok;
    logic room;
    logic rden;
    logic capture;
    logic pop;
    logic last_pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words in flight from the FIFO already own a buffer slot.
    assign room     = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
    assign rden     = (state_q == S_READ) & ~empty_i
                    & (issued_q < len_q) & room;
    assign capture  = inflight_q;
    assign pop      = (occ_q != 2'd0) & m_ready_i;
    assign last_pop = pop & (delivered_q + LEN_WIDTH'(1) == len_q);
    assign start_ok = (state_q == S_IDLE) & start_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (last_pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            head_q      <= 2'd0;
            tail_q      <= 2'd0;
            occ_q       <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= rden;

            if (start_ok) begin
                len_q       <= len_i;
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (rden) begin
                    issued_q <= issued_q + LEN_WIDTH'(1);
                end
                if (pop) begin
                    delivered_q <= delivered_q + LEN_WIDTH'(1);
                end
            end

            if (capture) begin
                for (int i = 0; i < 3; i++) begin
                    if (tail_q == 2'(i)) begin
                        mem_q[i] <= rdata_i;
                    end
                end
                tail_q <= ptr_next(tail_q);
            end

            if (pop) begin
                head_q <= ptr_next(head_q);
            end

            case ({capture, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_comb begin
        m_data_o = mem_q[0];
        if (head_q == 2'd1) begin
            m_data_o = mem_q[1];
        end else if (head_q == 2'd2) begin
            m_data_o = mem_q[2];
        end
    end

    assign rden_o     = rden;
    assign busy_o     = (state_q == S_READ);
    assign done_o     = (state_q == S_DONE);
    assign rd_count_o = delivered_q;
    assign m_valid_o  = (occ_q != 2'd0);

endmodule
